decode_issue_stage: RTL

Registered instruction decode-and-issue stage for the 151 processor. It replaces the combinational controller and sits between fetch and the register-file/ALU stage. It splits each instruction into fields and applies the swap rule for the swap opcodes, then holds the result in one output register under a valid/ready handshake. A register scoreboard stalls issue on RAW and WAW hazards against writes still in flight.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/decode_scoreboard.sv | 63 ++++++
 rtl/decode_issue_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, swap opcodes, the decoded-instruction struct and
// the field-split / swap-rule helper used by decode_issue_stage.
package decode_pkg;

  localparam int ILEN_D   = 32;
  localparam int REG_AW_D = 6;
  localparam int OP_W_D   = 4;
  localparam int IMM_W_D  = ILEN_D - 1 - 2 * REG_AW_D - OP_W_D;

  localparam logic [OP_W_D-1:0] OP_SWAP_A = 4'b1011;
  localparam logic [OP_W_D-1:0] OP_SWAP_B = 4'b1001;

  typedef struct packed {
    logic                regwrite;
    logic                immsel;
    logic [REG_AW_D-1:0] rs;
    logic [REG_AW_D-1:0] rd;
    logic [OP_W_D-1:0]   aluop;
    logic [REG_AW_D-1:0] rt;
    logic [IMM_W_D-1:0]  imm;
  } decoded_t;

  // Split an instruction into its fields and apply the swap rule. The
  // all-zero NOP falls out naturally: every field is zero and regwrite is 0.
  function automatic decoded_t decode_fields(input logic [ILEN_D-1:0] instr);
    decoded_t d;
    d.regwrite = |instr;
    d.immsel   = instr[ILEN_D-1];
    d.rs       = instr[ILEN_D-2 -: REG_AW_D];
    d.rd       = instr[ILEN_D-2-REG_AW_D -: REG_AW_D];
    d.aluop    = instr[ILEN_D-2-2*REG_AW_D -: OP_W_D];
    d.imm      = instr[IMM_W_D-1:0];
    d.rt       = instr[IMM_W_D-1 -: REG_AW_D];
    if ((d.aluop == OP_SWAP_A) || (d.aluop == OP_SWAP_B)) begin
      // rt takes the original rs before rs is overwritten with rd
      d.rt = d.rs;
      d.rs = d.rd;
    end else begin
      d.rt = d.rt;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: one pending bit per register. Reports RAW/WAW hazards
// from the registered state only (no same-cycle writeback bypass). A set
// in the same cycle as a clear of the same register wins.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int REG_AW = REG_AW_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              rt_used_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              hazard_o,
  input  logic              set_valid_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic              clr_valid_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  input  logic              flush_valid_i,
  input  logic [REG_AW-1:0] flush_addr_i
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Hazard query against the registered pending vector
  always_comb begin
    hazard_o = pending_q[rs_i] | (rt_used_i & pending_q[rt_i]) | pending_q[rd_i];
  end

  // Next pending vector: clears first, then the set so that set wins
  always_comb begin
    pending_d = pending_q;
    if (clr_valid_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (flush_valid_i) begin
      pending_d[flush_addr_i] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (set_valid_i) begin
      pending_d[set_addr_i] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Pending vector register, emptied immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: registered decode-and-issue stage. Decodes the offered
// instruction, holds it in a single output register under valid/ready, and
// (with DECODE_SCOREBOARD_EN defined) stalls on RAW/WAW hazards against
// register writes still in flight. Without the macro the hazard is tied off
// and writeback inputs are ignored. Field widths follow decode_pkg.
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int ILEN   = ILEN_D,
  parameter int REG_AW = REG_AW_D,
  parameter int OP_W   = OP_W_D,
  parameter int IMM_W  = ILEN - 1 - 2 * REG_AW - OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ILEN-1:0]   in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic              out_immsel,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rd,
  output logic [REG_AW-1:0] out_rt,
  output logic [OP_W-1:0]   out_aluop,
  output logic [IMM_W-1:0]  out_imm,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic              flush
);

  decoded_t dec_s;
  decoded_t data_q;
  decoded_t data_d;
  logic     valid_q;
  logic     valid_d;
  logic     hazard_s;
  logic     accept_s;
  logic     flush_clr_s;

  // Decode the offered instruction
  always_comb begin
    dec_s = decode_fields(in_instr);
  end

  // The held instruction is dropped by flush; release its pending bit
  assign flush_clr_s = flush & valid_q & data_q.regwrite;

`ifdef DECODE_SCOREBOARD_EN
  logic sb_hazard_s;

  decode_scoreboard #(
    .REG_AW(REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs_i         (dec_s.rs),
    .rt_i         (dec_s.rt),
    .rt_used_i    (~dec_s.immsel),
    .rd_i         (dec_s.rd),
    .hazard_o     (sb_hazard_s),
    .set_valid_i  (accept_s & dec_s.regwrite),
    .set_addr_i   (dec_s.rd),
    .clr_valid_i  (wb_valid),
    .clr_addr_i   (wb_addr),
    .flush_valid_i(flush_clr_s),
    .flush_addr_i (data_q.rd)
  );

  // A NOP never stalls, even when register 0 is pending
  assign hazard_s = sb_hazard_s & dec_s.regwrite;
`else
  logic unused_sb_s;

  assign unused_sb_s = ^{wb_valid, wb_addr, flush_clr_s};
  assign hazard_s    = 1'b0;
`endif

  // Accept when the output slot is free or draining, with no hazard or flush
  always_comb begin
    in_ready = (~valid_q | out_ready) & ~hazard_s & ~flush;
    accept_s = in_valid & in_ready;
  end

  // Output register next state: flush drops, accept loads, consume empties
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      data_d  = dec_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register; fields hold while stalled by out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_regwrite = data_q.regwrite;
  assign out_immsel   = data_q.immsel;
  assign out_rs       = data_q.rs;
  assign out_rd       = data_q.rd;
  assign out_rt       = data_q.rt;
  assign out_aluop    = data_q.aluop;
  assign out_imm      = data_q.imm;

endmodule
